// File: rtl/contador_gray_param.sv
// contador_gray_param: up/down binary counter with a registered Gray-coded copy.
// Supports a synchronous load, wrap or saturate behaviour at the limits, a
// one-cycle terminal-count pulse and a sticky "held at limit" flag.
module contador_gray_param #(
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enable,
  input  logic             up_down,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] salida_gray,
  output logic [WIDTH-1:0] salida_bin,
  output logic             valid_out,
  output logic             tc,
  output logic             saturado
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CONTANDO = 2'd1,
    SATURADO = 2'd2
  } estado_t;

  localparam logic [WIDTH-1:0] MAX_BIN   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_BIN   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_BIN   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] RESET_BIN = WIDTH'(RESET_VAL);

  estado_t          estado_q;
  estado_t          estado_d;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_q;
  logic             valid_q;
  logic             valid_d;
  logic             tc_q;
  logic             tc_d;
  logic             at_limit;
  logic [WIDTH-1:0] bin_step;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Detect whether the next step in the selected direction hits a limit, and
  // precompute that step (natural modular arithmetic gives the wrap value).
  always_comb begin
    at_limit = up_down ? (bin_q == MAX_BIN) : (bin_q == MIN_BIN);
    bin_step = up_down ? (bin_q + ONE_BIN) : (bin_q - ONE_BIN);
  end

  // Next-state and next-output decision: load beats enable; a saturate-mode
  // hit at the limit holds the count and pulses tc only on entry to SATURADO.
  always_comb begin
    bin_d    = bin_q;
    valid_d  = 1'b0;
    tc_d     = 1'b0;
    estado_d = (estado_q == SATURADO) ? SATURADO : IDLE;
    if (load) begin
      bin_d    = load_value;
      valid_d  = 1'b1;
      estado_d = enable ? CONTANDO : IDLE;
    end else if (enable) begin
      if (at_limit && sat_mode) begin
        tc_d     = (estado_q != SATURADO);
        estado_d = SATURADO;
      end else begin
        bin_d    = bin_step;
        valid_d  = 1'b1;
        tc_d     = at_limit;
        estado_d = CONTANDO;
      end
    end
  end

  // State and output registers; binary and Gray copies update together so
  // they never skew against each other.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      bin_q    <= RESET_BIN;
      gray_q   <= to_gray(RESET_BIN);
      valid_q  <= 1'b0;
      tc_q     <= 1'b0;
      estado_q <= IDLE;
    end else begin
      bin_q    <= bin_d;
      gray_q   <= to_gray(bin_d);
      valid_q  <= valid_d;
      tc_q     <= tc_d;
      estado_q <= estado_d;
    end
  end

  assign salida_bin  = bin_q;
  assign salida_gray = gray_q;
  assign valid_out   = valid_q;
  assign tc          = tc_q;
  assign saturado    = (estado_q == SATURADO);

endmodule

// File: tb/tb_contador_gray_param.sv
// Self-checking bench for contador_gray_param: directed limit scenarios
// followed by randomized traffic, all checked against an integer model.
module tb_contador_gray_param;

  localparam int WIDTH     = 4;
  localparam int RESET_VAL = 0;
  localparam int MODV      = 1 << WIDTH;
  localparam int MAXV      = MODV - 1;

  logic             clk = 1'b0;
  logic             reset_L;
  logic             enable;
  logic             up_down;
  logic             sat_mode;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] salida_gray;
  logic [WIDTH-1:0] salida_bin;
  logic             valid_out;
  logic             tc;
  logic             saturado;

  int checks = 0;
  int errors = 0;

  int m_bin;
  int m_valid;
  int m_tc;
  int m_sat;
  int prev_bin;
  int prev_gray_dut;

  contador_gray_param #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .enable     (enable),
    .up_down    (up_down),
    .sat_mode   (sat_mode),
    .load       (load),
    .load_value (load_value),
    .salida_gray(salida_gray),
    .salida_bin (salida_bin),
    .valid_out  (valid_out),
    .tc         (tc),
    .saturado   (saturado)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_bin   = RESET_VAL;
    m_valid = 0;
    m_tc    = 0;
    m_sat   = 0;
  endtask

  // Reference behaviour in plain integers: a counter that either wraps
  // modulo 2**WIDTH or sticks at 0/MAX, remembering whether it is stuck.
  task automatic modelStep();
    int at_lim;
    if (load) begin
      m_bin   = int'(load_value);
      m_valid = 1;
      m_tc    = 0;
      m_sat   = 0;
    end else if (enable) begin
      at_lim = up_down ? (m_bin == MAXV) : (m_bin == 0);
      if (at_lim && sat_mode) begin
        m_tc    = m_sat ? 0 : 1;
        m_sat   = 1;
        m_valid = 0;
      end else begin
        m_bin   = (m_bin + (up_down ? 1 : MODV - 1)) % MODV;
        m_tc    = at_lim;
        m_valid = 1;
        m_sat   = 0;
      end
    end else begin
      m_valid = 0;
      m_tc    = 0;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_bin"},  int'(salida_bin),  m_bin);
    checkOutput({tag, "_gray"}, int'(salida_gray), gray_of(m_bin));
    checkOutput({tag, "_valid"}, int'(valid_out), m_valid);
    checkOutput({tag, "_tc"},    int'(tc),        m_tc);
    checkOutput({tag, "_sat"},   int'(saturado),  m_sat);
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model on the
  // rising edge and compare shortly after it.
  task automatic applyStimulus(input logic en, input logic up, input logic sat,
                               input logic ld, input int lv, input string tag);
    logic stepping;
    @(negedge clk);
    prev_gray_dut = int'(salida_gray);
    enable     = en;
    up_down    = up;
    sat_mode   = sat;
    load       = ld;
    load_value = WIDTH'(lv);
    stepping   = en && !ld;
    @(posedge clk);
    prev_bin = m_bin;
    modelStep();
    #1;
    checkAll(tag);
    if (stepping)
      checkOutput({tag, "_ham"}, $countones(prev_gray_dut ^ int'(salida_gray)),
                  (m_bin != prev_bin) ? 1 : 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    enable = 1'b0; up_down = 1'b1; sat_mode = 1'b0; load = 1'b0; load_value = '0;
    reset_L = 1'b0;
    #1;
    modelReset();
    checkAll("reset");
    #2;
    reset_L = 1'b1;
  endtask

  // Async reset pulse placed between two rising edges.
  task automatic midReset(input string tag);
    #2;
    reset_L = 1'b0;
    #1;
    modelReset();
    checkAll(tag);
    reset_L = 1'b1;
  endtask

  initial begin
    reset_L = 1'b1; enable = 1'b0; up_down = 1'b1; sat_mode = 1'b0;
    load = 1'b0; load_value = '0;
    doReset();

    // Wrap-mode up count through a full period.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, "wrap_up");
      checkOutput("wrap_up_const_bin", int'(salida_bin), (i + 1) % 16);
      checkOutput("wrap_up_const_tc", int'(tc), (i == 15) ? 1 : 0);
    end
    checkOutput("wrap_gray_zero", int'(salida_gray), 0);

    // Saturate at the top.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 14, "load14");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0, "sat_up1");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0, "sat_up2");
    checkOutput("sat_tc_first", int'(tc), 1);
    checkOutput("sat_flag_first", int'(saturado), 1);
    checkOutput("sat_hold_valid", int'(valid_out), 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0, "sat_up3");
    checkOutput("sat_tc_second", int'(tc), 0);
    checkOutput("sat_hold_bin", int'(salida_bin), 15);

    // Idle while saturated keeps the flag.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 0, "sat_idle");

    // Reverse away from the top, run down to the bottom and saturate there.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 0, "rev_down");
    checkOutput("rev_bin14", int'(salida_bin), 14);
    checkOutput("rev_sat_clear", int'(saturado), 0);
    for (int i = 0; i < 14; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 0, "down_run");
    checkOutput("down_at_zero", int'(salida_bin), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 0, "sat_low");
    checkOutput("sat_low_tc", int'(tc), 1);
    checkOutput("sat_low_flag", int'(saturado), 1);

    // Leaving saturate mode while held wraps on the next step.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, "unsat_wrap");
    checkOutput("unsat_wrap_bin", int'(salida_bin), 15);
    checkOutput("unsat_wrap_tc", int'(tc), 1);

    // Load wins over enable.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 9, "load9");
    checkOutput("load9_const_bin", int'(salida_bin), 9);
    checkOutput("load9_const_gray", int'(salida_gray), 13);

    // Asynchronous reset while counting at 7.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 6, "load6");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, "to7");
    checkOutput("at7", int'(salida_bin), 7);
    midReset("async_rst");
    checkOutput("async_rst_const_bin", int'(salida_bin), 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, "resume");

    // Randomized traffic with occasional mid-cycle resets.
    for (int i = 0; i < 400; i++) begin
      logic r_en, r_up, r_sat, r_ld;
      int   r_lv;
      r_en  = ($urandom_range(3, 0) != 0);
      r_up  = 1'($urandom_range(1, 0));
      r_sat = ($urandom_range(5, 0) < 3);
      r_ld  = ($urandom_range(9, 0) == 0);
      r_lv  = ($urandom_range(3, 0) == 0) ? (($urandom_range(1, 0) == 0) ? 0 : MAXV)
                                          : int'($urandom_range(MAXV, 0));
      applyStimulus(r_en, r_up, r_sat, r_ld, r_lv, "rand");
      if ($urandom_range(59, 0) == 0)
        midReset("rand_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/contador_gray_param.md
CONTADOR_GRAY_PARAM -- requirements
Module: contador_gray_param

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits (legal range 2..16).
REQ-002 Parameter: RESET_VAL, default 0, binary value loaded on reset (must be < 2**WIDTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_L  input  1  asynchronous active-low reset.
REQ-005 enable  input  1  advance counter one step when high.
REQ-006 up_down  input  1  direction: 1 = count up, 0 = count down.
REQ-007 sat_mode  input  1  limit behaviour: 1 = saturate at limit, 0 = wrap around.
REQ-008 load  input  1  synchronous load request.
REQ-009 load_value  input  WIDTH  binary value to load.
REQ-010 salida_gray  output  WIDTH  Gray-coded count, registered.
REQ-011 salida_bin  output  WIDTH  binary count, registered.
REQ-012 valid_out  output  1  high when outputs changed due to load or enable on the previous edge.
REQ-013 tc  output  1  terminal-count pulse, registered.
REQ-014 saturado  output  1  high while the counter is held at a limit in saturate mode.

Function
REQ-015 Internal state SHALL be a WIDTH-bit binary register; salida_gray SHALL equal bin ^ (bin >> 1), registered with salida_bin (same cycle, no skew).
REQ-016 Latency SHALL be one clock: inputs sampled at edge N appear on outputs after edge N.
REQ-017 Priority SHALL be load > enable; load with enable high performs load only.
REQ-018 On load: bin <= load_value; valid_out <= 1; tc <= 0; saturado <= 0.
REQ-019 On enable, up, bin < MAX (2**WIDTH-1): bin <= bin+1; valid_out <= 1.
REQ-020 On enable, down, bin > 0: bin <= bin-1; valid_out <= 1.
REQ-021 Wrap mode, up at MAX: bin <= 0, tc <= 1 for exactly one cycle; down at 0: bin <= MAX, tc <= 1 for one cycle.
REQ-022 Saturate mode, up at MAX or down at 0: bin unchanged, tc <= 1 on the first such cycle only, saturado <= 1, valid_out <= 0.
REQ-023 saturado SHALL clear on the first edge that moves bin away from the limit (direction reversal or load).
REQ-024 enable low and load low: bin, saturado hold; valid_out <= 0; tc <= 0.
REQ-025 FSM states SHALL be IDLE (no activity), CONTANDO (enable stepping), SATURADO (held at limit); IDLE->CONTANDO on enable; CONTANDO->IDLE on enable low; CONTANDO->SATURADO on REQ-022 condition; SATURADO->CONTANDO on reversal; any state->IDLE on load with enable low, ->CONTANDO on load with enable high.
REQ-026 sat_mode change mid-count SHALL take effect on the next edge; leaving saturate mode while in SATURADO SHALL wrap on the next enabled step toward the limit.
REQ-027 Gray output SHALL change in exactly one bit per counting step, including wrap (MAX<->0).

Reset
REQ-028 reset_L low SHALL immediately (asynchronously) force bin = RESET_VAL, salida_gray = gray(RESET_VAL), valid_out = 0, tc = 0, saturado = 0, FSM = IDLE.
REQ-029 Reset asserted mid-count SHALL override load and enable; counting SHALL resume on the first rising edge after reset_L deasserts.

Verification (WIDTH=4, RESET_VAL=0)
REQ-030 Reset then enable=1, up=1, sat_mode=0 for 16 cycles -> salida_bin 1..15,0; salida_gray 0001,0011,...,1000,0000; tc=1 only on the 15->0 cycle.
REQ-031 Load 14 then up, sat_mode=1, 3 cycles -> 15,15,15; tc=1 on first hold cycle only; saturado=1 from that cycle; valid_out=0 while held.
REQ-032 At 15 saturated, up_down=0 -> 14, saturado=0, valid_out=1; continue to 0 then one more -> holds 0, tc pulse, saturado=1.
REQ-033 load=1, load_value=9, enable=1 same cycle -> salida_bin=9, salida_gray=1101, no increment.
REQ-034 reset_L pulsed low between edges while counting at 7 -> outputs 0 before next edge, valid_out=0.
REQ-035 Every cycle, checker compares salida_gray against bin^(bin>>1) and asserts Hamming distance <=1 between consecutive counting values.
